// File: rtl/pool_window_gen.sv
// Streaming KxK stride-K window builder feeding max_pool2d from a raster pixel stream.
// Optional `POOL_WINDOW_GEN_SOF_EN adds an in_sof input that realigns the frame to (0,0).
module pool_window_gen #(
  parameter int unsigned K     = 2,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_pixel,
`ifdef POOL_WINDOW_GEN_SOF_EN
  input  logic                    in_sof,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_window [K*K],
  output logic                    out_last
);

  localparam int unsigned CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned SW       = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned LB_DEPTH = (K - 1) * IMG_W;
  localparam int unsigned AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int unsigned SRW      = (K - 1) * WIDTH;

  if (K < 2) begin : g_bad_k
    $error("pool_window_gen: K must be at least 2");
  end
  if (IMG_W % K != 0) begin : g_bad_w
    $error("pool_window_gen: IMG_W must be a multiple of K");
  end
  if (IMG_H % K != 0) begin : g_bad_h
    $error("pool_window_gen: IMG_H must be a multiple of K");
  end

  logic [CW-1:0]           col, cur_col;
  logic [RW-1:0]           row, cur_row;
  logic [SW-1:0]           col_sub, cur_col_sub;
  logic [SW-1:0]           row_sub, cur_row_sub;
  logic                    accept, complete, frame_end, last_row_of_band;
  logic [AW-1:0]           lb_wr_idx;
  logic signed [WIDTH-1:0] line_buf [LB_DEPTH];
  logic [SRW-1:0]          shift_reg;
  logic signed [WIDTH-1:0] win_next [K*K];

  // Handshake and effective pixel position (a start-of-frame pixel forces (0,0)).
  always_comb begin
    in_ready    = !out_valid || out_ready;
    accept      = in_valid && in_ready;
    cur_col     = col;
    cur_row     = row;
    cur_col_sub = col_sub;
    cur_row_sub = row_sub;
`ifdef POOL_WINDOW_GEN_SOF_EN
    if (in_sof) begin
      cur_col     = '0;
      cur_row     = '0;
      cur_col_sub = '0;
      cur_row_sub = '0;
    end
`endif
    last_row_of_band = (cur_row_sub == SW'(K - 1));
    complete         = accept && last_row_of_band && (cur_col_sub == SW'(K - 1));
    frame_end        = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
    lb_wr_idx        = AW'(32'(cur_row_sub) * IMG_W + 32'(cur_col));
  end

  // Raster position counters; sub-counters track position within the K band.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      col_sub <= '0;
      row_sub <= '0;
    end else if (accept) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col     <= '0;
        col_sub <= '0;
        if (frame_end) begin
          row     <= '0;
          row_sub <= '0;
        end else begin
          row     <= cur_row + 1'b1;
          row_sub <= last_row_of_band ? '0 : cur_row_sub + 1'b1;
        end
      end else begin
        col     <= cur_col + 1'b1;
        col_sub <= (cur_col_sub == SW'(K - 1)) ? '0 : cur_col_sub + 1'b1;
      end
    end
  end

  // Line buffers and current-row shift register carry data only, no reset.
  always_ff @(posedge clk) begin
    if (accept && !last_row_of_band) begin
      line_buf[lb_wr_idx] <= in_pixel;
    end
    if (accept && last_row_of_band) begin
      shift_reg <= SRW'({shift_reg, in_pixel});
    end
  end

  // Assemble the candidate window: buffered rows, then shift register, then the live pixel.
  for (genvar r = 0; r < int'(K) - 1; r++) begin : g_lb_row
    for (genvar c = 0; c < int'(K); c++) begin : g_lb_col
      assign win_next[r*K + c] =
        line_buf[AW'(r * IMG_W + c - (K - 1)) + AW'(cur_col)];
    end
  end
  for (genvar c = 0; c < int'(K) - 1; c++) begin : g_sr
    assign win_next[(K-1)*K + c] = shift_reg[(K - 2 - c)*WIDTH +: WIDTH];
  end
  assign win_next[K*K - 1] = in_pixel;

  // Output register: reload on completion, otherwise clear on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_window <= '{default: '0};
    end else if (complete) begin
      out_valid  <= 1'b1;
      out_last   <= frame_end;
      out_window <= win_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench for pool_window_gen (K=2, 4x4 frames) against a frame-level window model.
module tb_pool_window_gen;

  localparam int K    = 2;
  localparam int W    = 16;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int NPIX = IW * IH;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_pixel = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] out_window [K*K];
  logic                out_last;
`ifdef POOL_WINDOW_GEN_SOF_EN
  logic                in_sof = 1'b0;
`endif

  pool_window_gen #(.K(K), .WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
`ifdef POOL_WINDOW_GEN_SOF_EN
    .in_sof     (in_sof),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v[4];
    bit last;
    int cyc;
  } win_t;

  win_t exp_q[$];
  win_t got_q[$];
  win_t e, g, held_w;
  int   img[IH][IW];
  int   pos = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   held = 0;
  bit   arm_stall = 0;
  bit   force_low = 0;
  int   stall_left = 0;
  int   ready_low_cycles = 0;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Frame model: place each accepted pixel at its raster spot, emit a window at each KxK corner.
  function automatic void model_accept(int v, bit sof);
    int r, c;
    win_t w;
    if (sof) pos = 0;
    r = pos / IW;
    c = pos % IW;
    img[r][c] = v;
    if ((r % K == K - 1) && (c % K == K - 1)) begin
      w.v[0] = img[r-1][c-1];
      w.v[1] = img[r-1][c];
      w.v[2] = img[r][c-1];
      w.v[3] = img[r][c];
      w.last = (pos == NPIX - 1);
      w.cyc  = cyc;
      exp_q.push_back(w);
    end
    pos = (pos + 1) % NPIX;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: optional 3-cycle stall on the first window after arming.
  always @(posedge clk) begin
    #1;
    if (arm_stall && out_valid) begin
      arm_stall  = 0;
      stall_left = 3;
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = !force_low;
    end
  end

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
      for (int i = 0; i < K*K; i++) chk("rst_out_window", int'(out_window[i]), 0);
      held = 0;
    end else begin
      chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
      if (!in_ready) ready_low_cycles++;
      if (out_valid) begin
        if (!held) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_window: got out_valid=1 want no window pending");
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < K*K; i++) begin
              g.v[i] = int'(out_window[i]);
              chk("window_elem", g.v[i], e.v[i]);
            end
            g.last = out_last;
            g.cyc  = cyc;
            chk("window_last", int'(g.last), int'(e.last));
            chk("window_latency", cyc, e.cyc + 1);
            got_q.push_back(g);
            held_w = g;
          end
        end else begin
          for (int i = 0; i < K*K; i++) chk("hold_elem", int'(out_window[i]), held_w.v[i]);
          chk("hold_last", int'(out_last), int'(held_w.last));
        end
        held = !out_ready;
      end else begin
        held = 0;
        if (exp_q.size() > 0 && exp_q[0].cyc + 1 < cyc) begin
          chk("window_overdue", cyc, exp_q[0].cyc + 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_pixel(int v, bit sof);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1;
    in_pixel = W'(v);
`ifdef POOL_WINDOW_GEN_SOF_EN
    in_sof = sof;
`endif
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) model_accept(v, sof);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept want accept within 50 cycles");
    end
    in_valid = 1'b0;
`ifdef POOL_WINDOW_GEN_SOF_EN
    in_sof = 1'b0;
`endif
  endtask

  task automatic send_frame(int base, bit sof_first);
    for (int i = 0; i < NPIX; i++) send_pixel(base + i, sof_first && (i == 0));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic chk_win(string name, int idx, int a, int b, int c, int d);
    if (idx >= got_q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0d windows want index %0d present", name, got_q.size(), idx);
    end else begin
      chk(name, got_q[idx].v[0], a);
      chk(name, got_q[idx].v[1], b);
      chk(name, got_q[idx].v[2], c);
      chk(name, got_q[idx].v[3], d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx;
    int v;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plain frame, no backpressure.
    got_q.delete();
    ready_low_cycles = 0;
    send_frame(0, 1'b0);
    drain();
    chk("t1_count", got_q.size(), 4);
    chk("t1_ready_low", ready_low_cycles, 0);
    chk_win("t1_w0", 0, 0, 1, 4, 5);
    chk_win("t1_w1", 1, 2, 3, 6, 7);
    chk_win("t1_w3", 3, 10, 11, 14, 15);
    if (got_q.size() == 4) begin
      chk("t1_w0_last", int'(got_q[0].last), 0);
      chk("t1_w3_last", int'(got_q[3].last), 1);
      chk("t1_w1_spacing", got_q[1].cyc - got_q[0].cyc, 2);
    end

    // Downstream stall for 3 cycles on the first window.
    got_q.delete();
    ready_low_cycles = 0;
    arm_stall = 1;
    send_frame(0, 1'b0);
    drain();
    chk("t2_count", got_q.size(), 4);
    chk("t2_ready_low", ready_low_cycles, 3);
    chk_win("t2_w0", 0, 0, 1, 4, 5);
    chk_win("t2_w2", 2, 8, 9, 12, 13);
    chk_win("t2_w3", 3, 10, 11, 14, 15);

    // Signed extremes in the last window.
    got_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      v = i;
      if (i == 10) v = -32768;
      if (i == 11) v = 32767;
      if (i == 14) v = -1;
      if (i == 15) v = 0;
      send_pixel(v, 1'b0);
    end
    drain();
    chk_win("t3_w3", 3, -32768, 32767, -1, 0);
    if (got_q.size() == 4) begin
      mx = got_q[3].v[0];
      for (int i = 1; i < 4; i++) if (got_q[3].v[i] > mx) mx = got_q[3].v[i];
      chk("t3_max", mx, 32767);
    end

    // Back-to-back frames.
    got_q.delete();
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    drain();
    chk("t4_count", got_q.size(), 8);
    chk_win("t4_w4", 4, 100, 101, 104, 105);
    if (got_q.size() == 8) begin
      chk("t4_w3_last", int'(got_q[3].last), 1);
      chk("t4_w4_last", int'(got_q[4].last), 0);
      chk("t4_w7_last", int'(got_q[7].last), 1);
    end

    // Reset with a window pending and downstream blocked.
    force_low = 1;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_pixel(i, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_pending_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    exp_q.delete();
    pos = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_low = 0;
    out_ready = 1'b1;
    got_q.delete();
    send_frame(0, 1'b0);
    drain();
    chk("t5_count", got_q.size(), 4);
    chk_win("t5_w0", 0, 0, 1, 4, 5);
    chk_win("t5_w3", 3, 10, 11, 14, 15);

`ifdef POOL_WINDOW_GEN_SOF_EN
    // Junk prefix, then a frame marked by start-of-frame.
    got_q.delete();
    for (int i = 0; i < 3; i++) send_pixel(999, 1'b0);
    send_frame(0, 1'b1);
    drain();
    chk("t6_count", got_q.size(), 4);
    chk_win("t6_w0", 0, 0, 1, 4, 5);
    chk_win("t6_w3", 3, 10, 11, 14, 15);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
